ram_rr_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port synchronous RAM (1-cycle read latency, read-during-write returns old data) between a CPU-side master (port 0) and a secondary master (port 1, e.g. DMA/video fetch).
- Grants one access per cycle round-robin, supports a lock for atomic read-modify-write sequences, and returns read data with a per-port valid strobe.
- Sits directly between the masters and the RAM's clk/ena/wea/addr/din/dout pins.

---
 rtl/ram_rr_arbiter_if.sv | 33 +++
 rtl/ram_rr_arbiter.sv | 80 ++++++++
 tb/tb_ram_rr_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ram_rr_arbiter_if.sv
// Bus bundle between the two masters, the round-robin RAM arbiter and the RAM pins.
// The arbiter uses the slave modport; the requesting side uses master.
interface ram_rr_arbiter_if #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 8
);
    logic                 req0, we0, lock0, ack0, rvalid0;
    logic [ADDR_BITS-1:0] addr0;
    logic [DATA_BITS-1:0] wdata0;
    logic                 req1, we1, lock1, ack1, rvalid1;
    logic [ADDR_BITS-1:0] addr1;
    logic [DATA_BITS-1:0] wdata1;
    logic [DATA_BITS-1:0] rdata;
    logic                 ram_ena, ram_wea;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_BITS-1:0] ram_din, ram_dout;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  ram_dout,
        output ack0, rvalid0, ack1, rvalid1, rdata,
        output ram_ena, ram_wea, ram_addr, ram_din
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output ram_dout,
        input  ack0, rvalid0, ack1, rvalid1, rdata,
        input  ram_ena, ram_wea, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two masters,
// with an owner lock for atomic read-modify-write and a bounded lock duration.
module ram_rr_arbiter #(
    parameter int ADDR_BITS    = 10,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    ram_rr_arbiter_if.slave bus
);
    localparam int CNT_W = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t             state_q;
    logic               last_q;
    logic [CNT_W-1:0]   lock_cnt_q;
    logic               rvalid0_q, rvalid1_q;

    logic               gnt0, gnt1, gnt, g_we, g_lock, timeout;
    logic [CNT_W-1:0]   cnt_inc;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes first.
                gnt0 = bus.req0 && (!bus.req1 || last_q);
                gnt1 = bus.req1 && (!bus.req0 || !last_q);
            end
            OWN0:    gnt0 = bus.req0;
            OWN1:    gnt1 = bus.req1;
            default: ;
        endcase
        gnt0 = gnt0 && reset_n;
        gnt1 = gnt1 && reset_n;
    end

    assign gnt     = gnt0 | gnt1;
    assign g_we    = gnt1 ? bus.we1   : bus.we0;
    assign g_lock  = gnt1 ? bus.lock1 : bus.lock0;
    assign cnt_inc = (lock_cnt_q == {CNT_W{1'b1}}) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
    // The grant that brings the count to LOCK_TIMEOUT is the last locked one.
    assign timeout = (LOCK_TIMEOUT != 0) && (cnt_inc == CNT_W'(LOCK_TIMEOUT));

    assign bus.ack0     = gnt0;
    assign bus.ack1     = gnt1;
    assign bus.ram_ena  = gnt;
    assign bus.ram_wea  = gnt && g_we;
    assign bus.ram_addr = gnt1 ? bus.addr1  : bus.addr0;
    assign bus.ram_din  = gnt1 ? bus.wdata1 : bus.wdata0;
    assign bus.rdata    = bus.ram_dout;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 && !bus.we0;
            rvalid1_q <= gnt1 && !bus.we1;
            if (gnt) begin
                last_q <= gnt1;
                if (!g_lock || timeout) begin
                    state_q    <= IDLE;
                    lock_cnt_q <= '0;
                end else begin
                    state_q    <= gnt1 ? OWN1 : OWN0;
                    lock_cnt_q <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: expected read returns go into a scoreboard queue,
// a negedge monitor pops them whenever an rvalid strobe appears.
module tb_ram_rr_arbiter;
    localparam int AB = 10;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_rr_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus();

    ram_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .LOCK_TIMEOUT(3)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Single-port RAM model: 1-cycle read, read-during-write returns old data.
    logic [DB-1:0] mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wea) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        int            port;
        logic [DB-1:0] data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input int p, input logic [DB-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic cycle(input string name, input bit a0, input bit a1);
        @(negedge clk);
        chk({name, "_ack0"}, int'(bus.ack0), int'(a0));
        chk({name, "_ack1"}, int'(bus.ack1), int'(a1));
        chk({name, "_ena"},  int'(bus.ram_ena), int'(a0 | a1));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && (bus.rvalid0 || bus.rvalid1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: rvalid0=%0b rvalid1=%0b with nothing outstanding",
                         bus.rvalid0, bus.rvalid1);
            end else begin
                mon_e = q.pop_front();
                chk("rvalid_port", bus.rvalid1 ? 1 : 0, mon_e.port);
                chk("rvalid_both", int'(bus.rvalid0 & bus.rvalid1), 0);
                chk("rdata", int'(bus.rdata), int'(mon_e.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
        mem[10'h010] = 8'hA5;
        mem[10'h020] = 8'h5A;
        bus.ram_dout = '0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset: outputs quiet even with requests pending.
        #12;
        chk("rst_ack0",    int'(bus.ack0), 0);
        chk("rst_ack1",    int'(bus.ack1), 0);
        chk("rst_ena",     int'(bus.ram_ena), 0);
        chk("rst_wea",     int'(bus.ram_wea), 0);
        chk("rst_rvalid0", int'(bus.rvalid0), 0);
        chk("rst_rvalid1", int'(bus.rvalid1), 0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read of preloaded 0x010.
        bus.req0 = 1'b1; bus.addr0 = 10'h010;
        expect_rd(0, 8'hA5);
        cycle("t1_rd", 1, 0);
        bus.req0 = 1'b0;
        cycle("t1_idle", 0, 0);

        // Contention from a fresh reset: 0,1,0,1.
        reset_n = 1'b0; #2; reset_n = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 10'h010;
        bus.req1 = 1'b1; bus.addr1 = 10'h000;
        for (int k = 0; k < 4; k++) begin
            expect_rd(k % 2, (k % 2) ? 8'h00 : 8'hA5);
            cycle("t2_rr", (k % 2) == 0, (k % 2) == 1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Port 1 writes the top address, reads it back, and 0x000 is untouched.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 10'h3FF; bus.wdata1 = 8'h3C;
        cycle("t3_wr", 0, 1);
        bus.we1 = 1'b0;
        expect_rd(1, 8'h3C);
        cycle("t3_rd", 0, 1);
        bus.addr1 = 10'h000;
        expect_rd(1, 8'h00);
        cycle("t3_rd0", 0, 1);
        bus.req1 = 1'b0;

        // Locked read-modify-write by port 0 while port 1 keeps requesting.
        bus.req1 = 1'b1; bus.addr1 = 10'h000;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b1; bus.addr0 = 10'h020;
        expect_rd(0, 8'h5A);
        cycle("t4_rd", 1, 0);
        bus.we0 = 1'b1; bus.wdata0 = 8'h21; bus.lock0 = 1'b0;
        cycle("t4_wr", 1, 0);
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        expect_rd(1, 8'h00);
        cycle("t4_p1", 0, 1);
        bus.addr1 = 10'h020;
        expect_rd(1, 8'h21);
        cycle("t4_chk", 0, 1);
        bus.req1 = 1'b0;

        // Lock timeout of 3 grants, then port 1 gets in.
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 10'h010;
        bus.req1 = 1'b1; bus.addr1 = 10'h3FF;
        for (int k = 0; k < 3; k++) begin
            expect_rd(0, 8'hA5);
            cycle("t5_own", 1, 0);
        end
        expect_rd(1, 8'h3C);
        cycle("t5_p1", 0, 1);
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
        cycle("t5_idle", 0, 0);

        // Async reset while port 1 owns the lock with a read outstanding.
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 10'h3FF;
        cycle("t6_lock", 0, 1);
        bus.req0 = 1'b1; bus.addr0 = 10'h010;
        chk("t6_pre_rvalid1", int'(bus.rvalid1), 1);
        chk("t6_pre_ack1",    int'(bus.ack1), 1);
        chk("t6_pre_ack0",    int'(bus.ack0), 0);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_rvalid1", int'(bus.rvalid1), 0);
        chk("t6_rst_ack0",    int'(bus.ack0), 0);
        chk("t6_rst_ack1",    int'(bus.ack1), 0);
        chk("t6_rst_ena",     int'(bus.ram_ena), 0);
        #1 reset_n = 1'b1;
        bus.lock1 = 1'b0;
        expect_rd(0, 8'hA5);
        cycle("t6_post", 1, 0);
        expect_rd(1, 8'h3C);
        cycle("t6_rr", 0, 1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle("t6_end", 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
